// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Mode encoding matches the 2-bit mode pin.
package shift_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SHL  = 2'd1,
        SHR  = 2'd2,
        LOAD = 2'd3
    } shift_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: accepts a start, counts shifts,
// and generates busy/done plus a per-cycle shift strobe.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] burst_len,
    output logic          accept,
    output logic          shift_en,
    output logic          shift_left,
    output logic          busy,
    output logic          done
);

    burst_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          done_q, done_d;
    logic          dir_ok;

    assign dir_ok = (mode == SHL) || (mode == SHR);

    // Next-state: accept in IDLE, count down in BURST.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        accept   = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && dir_ok) begin
                    accept = 1'b1;
                    dir_d  = (mode == SHL);
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = BURST;
                        cnt_d   = burst_len;
                    end
                end
            end
            BURST: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign shift_left = dir_q;
    assign busy       = (state_q == BURST);
    assign done       = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shl/shr/load plus
// a self-timed N-place burst with completion pulse.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_lsb,
    input  logic             ser_in_msb,
    input  logic             start,
    input  logic [CW-1:0]    burst_len,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;
    logic             shift_en;
    logic             shift_left;

    shift_burst_ctrl #(
        .CW(CW)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
        .accept    (accept),
        .shift_en  (shift_en),
        .shift_left(shift_left),
        .busy      (busy),
        .done      (done)
    );

    // Burst shifts win; manual ops only when idle and not accepting.
    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = shift_left ? {data_q[WIDTH-2:0], ser_in_lsb}
                                : {ser_in_msb, data_q[WIDTH-1:1]};
        end else if (en && !accept && !busy) begin
            unique case (shift_mode_e'(mode))
                HOLD: data_d = data_q;
                SHL:  data_d = {data_q[WIDTH-2:0], ser_in_lsb};
                SHR:  data_d = {ser_in_msb, data_q[WIDTH-1:1]};
                LOAD: data_d = data_in;
            endcase
        end
    end

    // Register contents with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out    = data_q;
    assign ser_out_msb = data_q[WIDTH-1];
    assign ser_out_lsb = data_q[0];

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the general successor to the fixed 4-bit parallel-in/parallel-out register. It supports hold, shift-left, shift-right and parallel load under mode control, with serial in/out at both ends. It also provides a self-timed burst mode that shifts N places autonomously and reports completion. It is intended as the common shift/serialiser primitive for the training SoC datapaths.

## Interface
- `WIDTH`, default 8: register width in bits, ≥ 2.
- `CW`, default $clog2(WIDTH+1): burst-length width (derived; do not override).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `en`  in  1  enables the manual mode operation; ignored while `busy`.
- `mode`  in  2  operation select: 0 HOLD, 1 SHL, 2 SHR, 3 LOAD.
- `data_in`  in  WIDTH  parallel load data.
- `ser_in_lsb`  in  1  bit entering bit 0 on SHL.
- `ser_in_msb`  in  1  bit entering bit WIDTH-1 on SHR.
- `start`  in  1  burst request; direction taken from `mode` (SHL/SHR only).
- `burst_len`  in  CW  number of shifts in the burst, 0..WIDTH.
- `data_out`  out  WIDTH  register contents.
- `ser_out_msb`  out  1  combinational `data_out[WIDTH-1]`.
- `ser_out_lsb`  out  1  combinational `data_out[0]`.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- Reset (`rst`=1 at an edge): `data_out`=0, `busy`=0, `done`=0, state IDLE, count 0. Reset overrides everything, including a burst in progress; the partial burst is abandoned and no `done` is produced.
- IDLE, `start`=0, `en`=1:
  - HOLD: keep the value.
  - SHL: `data_out` ← {`data_out[WIDTH-2:0]`, `ser_in_lsb`}.
  - SHR: `data_out` ← {`ser_in_msb`, `data_out[WIDTH-1:1]`}.
  - LOAD: `data_out` ← `data_in`.
- IDLE, `en`=0: hold.
- IDLE, `start`=1, `mode` ∈ {SHL, SHR} is the accept edge. Direction and `burst_len` are latched, and the register holds at this edge regardless of `en`.
  - `burst_len`=0: stay IDLE, `done`←1, `busy` stays 0.
  - `burst_len`≥1: go to BURST, `busy`←1, count←`burst_len`.
- IDLE, `start`=1, `mode` ∈ {HOLD, LOAD}: the start is ignored and the normal `en`/`mode` behaviour applies.
- BURST: each edge performs one shift in the latched direction, using the live `ser_in_*` pin, and decrements the count. `en`, `mode`, `data_in` and `start` are ignored.
  - On the edge that performs the final shift (count was 1): go to IDLE, `busy`←0, `done`←1.
- `done` is cleared on every edge where it is not being set, so it is exactly one cycle wide.

## Timing
- Manual operations: single-cycle latency; the result is visible after the sampling edge.
- Burst with N≥1 accepted at edge k:
  - `busy` is high from after edge k through edge k+N.
  - Shifts occur at edges k+1 … k+N.
  - `done` is high for one cycle after edge k+N.
  - A new `start` is accepted no earlier than edge k+N+1, which may coincide with `done`=1.
- Burst with N=0: `done` is high for one cycle after the accept edge; no shift occurs.
- `ser_out_*` are combinational from the register; they carry no extra latency.

## Structure
- Package `shift_pkg` holds:
  - `shift_mode_e` enum (HOLD, SHL, SHR, LOAD).
  - `burst_state_e` enum (IDLE, BURST).
- Sub-module `shift_burst_ctrl`: the FSM, the count register, and the `busy`/`done` generation. It outputs a per-cycle shift strobe and direction to the datapath in `univ_shift_reg`.

## Test plan
All scenarios use WIDTH=4.
- **Reset then load:** reset, then LOAD 4'b1010 with `en`=1 → `data_out`=1010 one cycle later; `busy`=0, `done`=0.
- **Manual shifts:** from 1010, SHL with `ser_in_lsb`=1 → 0101. Then SHR with `ser_in_msb`=0 → 0010. Then `en`=0 with SHL → 0010 (held).
- **Burst left, N=3:** from 1100, `start` with SHL, `ser_in_lsb`=1 → `busy` high for 3 cycles after accept. Register sequence 1001, 0011, 0111. `done` pulses once as `busy` falls.
- **Burst edge cases:**
  - `burst_len`=0 → `done` for one cycle, `busy` never high, data unchanged.
  - `start` with LOAD → a plain load, no burst.
  - `burst_len`=4 SHR with `ser_in_msb`=0 → `data_out`=0000.
- **Ignore during burst:** during a 4-shift burst, drive LOAD 4'b1111 with `en`=1 and a second `start` → both ignored; exactly 4 shifts and one `done`.
- **Reset mid-burst:** assert `rst` at the 2nd shift of an N=4 burst → `data_out`=0, `busy`=0, no `done`. A new burst is accepted on the next edge after `rst` drops.
